// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// In-order prefetch buffer of {pc, instr} entries with flush.
// The head is read directly from storage flops, so a word pushed at an edge
// becomes visible at the head only in the following cycle.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifq_entry_t               head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full-queue push is blocked defensively; upstream credits should prevent it.
    assign do_push    = push && (count != FULL);
    assign do_pop     = pop && head_valid;
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

    // Entry storage; no reset needed because count qualifies every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with credit-limited prefetch queue and
// redirect handling (flush plus discard of stale in-flight responses).
module instr_fetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    logic          fifo_valid;
    ifq_entry_t    push_entry;
    ifq_entry_t    head;

    // Every granted-but-unreturned word already owns a queue slot.
    assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    // Request is held low while reset is asserted so the bus is quiet.
    assign imem_req        = reset && !redirect && (credit_used < DEPTH_W);
    assign imem_addr       = fetch_pc;
    assign grant           = imem_req && imem_gnt;
    // A response with nothing outstanding is ignored rather than underflowing.
    assign resp            = imem_rvalid && (outstanding != '0);
    // A response arriving during a redirect is stale along with everything else.
    assign push            = resp && (drop_cnt == '0) && !redirect;
    assign pop             = fifo_valid && inst_ready;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign push_entry      = '{pc: resp_pc, instr: imem_rdata};

    assign inst_valid = fifo_valid;
    assign inst_out   = fifo_valid ? head.instr : NOP_INSTR;
    assign inst_pc    = fifo_valid ? head.pc : 32'h0000_0000;

    // Outstanding count after this cycle's grant and response.
    always_comb begin
        outstanding_nxt = outstanding;
        if (grant && !resp) begin
            outstanding_nxt = outstanding + ONE;
        end else if (!grant && resp) begin
            outstanding_nxt = outstanding - ONE;
        end
    end

    // Fetch/response PCs, credits and stale-response bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                // Anything still in flight after this edge predates the redirect.
                drop_cnt <= outstanding_nxt;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (resp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - ONE;
                end
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_b      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

endmodule
